// File: rtl/wb_stage_if.sv
// Multdiv-to-writeback result handshake.
// Master is the multdiv unit, slave is wb_stage.
interface wb_stage_if;
  logic        md_valid;
  logic        md_ready;
  logic [31:0] md_result;
  logic [4:0]  md_rd;
  logic        md_exc;
  logic        md_is_div;

  modport master (
    output md_valid, md_result, md_rd,
    output md_exc, md_is_div,
    input  md_ready
  );

  modport slave (
    input  md_valid, md_result, md_rd,
    input  md_exc, md_is_div,
    output md_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: RF write port arbitration between
// the MEM/WB latch and a 1-entry multdiv result buffer.
module wb_stage #(
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned MUL_RSTATUS = 4,
  parameter int unsigned DIV_RSTATUS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mw_ir_i,
  input  logic [31:0] mw_o_i,
  input  logic [31:0] mw_d_i,
  wb_stage_if.slave   md,
  output logic        rf_we_o,
  output logic [4:0]  rf_wr_o,
  output logic [31:0] rf_wd_o,
  output logic        wb_stall_o,
  output logic [31:0] retired_o
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

  logic        pend_v_q, pend_v_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;

  logic [4:0]  op;
  logic        dec_we;
  logic [4:0]  dec_rd;
  logic [31:0] dec_data;
  logic        p_wr;
  logic        stall_req;
  logic        pend_go;
  logic        xfer;
  logic [4:0]  in_rd;
  logic [31:0] in_data;

  assign op = mw_ir_i[31:27];

  // Decode the latched instruction into a write request
  always_comb begin
    dec_we   = 1'b0;
    dec_rd   = mw_ir_i[26:22];
    dec_data = mw_o_i;
    unique case (1'b1)
      (op == OP_R),
      (op == OP_ADDI): dec_we = 1'b1;
      (op == OP_LW): begin
        dec_we   = 1'b1;
        dec_data = mw_d_i;
      end
      (op == OP_JAL): begin
        dec_we = 1'b1;
        dec_rd = 5'd31;
      end
      (op == OP_SETX): begin
        dec_we   = 1'b1;
        dec_rd   = 5'd30;
        dec_data = {5'b0, mw_ir_i[26:0]};
      end
      default: ;
    endcase
  end

  assign p_wr = ~reset & dec_we & (dec_rd != 5'd0);
  assign stall_req =
    pend_v_q & p_wr & (wait_q == WAIT_MAX);
  assign pend_go =
    ~reset & pend_v_q & (~p_wr | stall_req);

  assign md.md_ready = ~reset & (~pend_v_q | pend_go);
  assign xfer = md.md_valid & md.md_ready;

  assign in_rd = md.md_exc ? 5'd30 : md.md_rd;
  assign in_data = md.md_exc
    ? (md.md_is_div ? 32'(DIV_RSTATUS)
                    : 32'(MUL_RSTATUS))
    : md.md_result;

  // Single RF write port: buffer wins when it drains
  always_comb begin
    rf_we_o = 1'b0;
    rf_wr_o = 5'd0;
    rf_wd_o = 32'd0;
    if (pend_go) begin
      rf_we_o = 1'b1;
      rf_wr_o = pend_rd_q;
      rf_wd_o = pend_data_q;
    end else if (p_wr) begin
      rf_we_o = 1'b1;
      rf_wr_o = dec_rd;
      rf_wd_o = dec_data;
    end
  end

  assign wb_stall_o = stall_req;
  assign retired_o  = retired_q;

  // Next state of pending buffer, starvation count, retire count
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    wait_d      = wait_q;
    if (pend_go || !pend_v_q)
      wait_d = 3'd0;
    else if (p_wr && wait_q != WAIT_MAX)
      wait_d = wait_q + 3'd1;
    if (pend_go)
      pend_v_d = 1'b0;
    if (xfer) begin
      pend_v_d    = (in_rd != 5'd0);
      pend_rd_d   = in_rd;
      pend_data_d = in_data;
    end
    retired_d = retired_q
      + {31'd0, ~stall_req & (mw_ir_i != 32'd0)};
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q    <= 1'b0;
      pend_rd_q   <= 5'd0;
      pend_data_q <= 32'd0;
      wait_q      <= 3'd0;
      retired_q   <= 32'd0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal
// expectations plus randomized traffic against a model.
module tb_wb_stage;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mw_ir = '0;
  logic [31:0] mw_o = '0;
  logic [31:0] mw_d = '0;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        wb_stall;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage_if mdi ();

  wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .mw_ir_i    (mw_ir),
    .mw_o_i     (mw_o),
    .mw_d_i     (mw_d),
    .md         (mdi.slave),
    .rf_we_o    (rf_we),
    .rf_wr_o    (rf_wr),
    .rf_wd_o    (rf_wd),
    .wb_stall_o (wb_stall),
    .retired_o  (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [4:0] op,
                                     logic [4:0] rd);
    return {op, rd, 22'd0};
  endfunction

  // Reference: what the ISA says a writeback does
  task automatic ref_dec(input logic [31:0] ir,
                         input logic [31:0] o,
                         input logic [31:0] d,
                         output bit we,
                         output logic [4:0] rd,
                         output logic [31:0] v);
    we = 0; rd = ir[26:22]; v = o;
    case (ir[31:27])
      5'd0, 5'd5: we = 1;
      5'd8: begin we = 1; v = d; end
      5'd3: begin we = 1; rd = 31; end
      5'd21: begin
        we = 1; rd = 30; v = {5'd0, ir[26:0]};
      end
      default: we = 0;
    endcase
    if (rd == 0) we = 0;
  endtask

  bit          m_init = 0;
  bit          m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pdat;
  int          m_loss;
  logic [31:0] m_ret;

  // Model check every cycle, sampled mid-cycle
  always @(negedge clk) begin
    bit pw, forced, drain, rdy, take;
    logic [4:0] prd, nrd;
    logic [31:0] pv, ndat;
    logic ewe;
    logic [4:0] ewr;
    logic [31:0] ewd;
    if (reset) begin
      chk("rst_we", rf_we, 0);
      chk("rst_ready", mdi.md_ready, 0);
      chk("rst_stall", wb_stall, 0);
      m_pv = 0; m_loss = 0; m_ret = 0;
      m_prd = 0; m_pdat = 0; m_init = 1;
    end else if (m_init) begin
      ref_dec(mw_ir, mw_o, mw_d, pw, prd, pv);
      forced = m_pv && pw && (m_loss >= MAX_WAIT);
      drain = m_pv && (!pw || forced);
      rdy = !m_pv || drain;
      take = mdi.md_valid && rdy;
      ewe = 0; ewr = 0; ewd = 0;
      if (drain) begin
        ewe = 1; ewr = m_prd; ewd = m_pdat;
      end else if (pw) begin
        ewe = 1; ewr = prd; ewd = pv;
      end
      chk("m_we", rf_we, ewe);
      chk("m_wr", rf_wr, ewr);
      chk("m_wd", rf_wd, ewd);
      chk("m_stall", wb_stall, forced);
      chk("m_ready", mdi.md_ready, rdy);
      chk("m_retired", retired, m_ret);
      if (!forced && mw_ir != 0) m_ret = m_ret + 1;
      if (drain || !m_pv) m_loss = 0;
      else if (pw) m_loss = m_loss + 1;
      if (drain) m_pv = 0;
      if (take) begin
        nrd = mdi.md_exc ? 5'd30 : mdi.md_rd;
        ndat = !mdi.md_exc ? mdi.md_result
             : mdi.md_is_div ? 32'd5 : 32'd4;
        m_pv = (nrd != 0);
        m_prd = nrd;
        m_pdat = ndat;
        m_loss = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic md_set(bit v, logic [4:0] rd,
                        logic [31:0] r, bit e, bit dv);
    mdi.md_valid = v;
    mdi.md_rd = rd;
    mdi.md_result = r;
    mdi.md_exc = e;
    mdi.md_is_div = dv;
  endtask

  initial begin
    bit hold_p, took;
    logic [31:0] ir;
    md_set(0, 0, 0, 0, 0);
    reset = 1;
    tick(); tick();
    #3;
    chk("reset_ready", mdi.md_ready, 0);
    chk("reset_we", rf_we, 0);
    tick();
    reset = 0;
    #3;
    chk("reset_retired", retired, 0);
    chk("reset_ready_after", mdi.md_ready, 1);

    // lw r5
    tick();
    mw_ir = mk(5'd8, 5'd5);
    mw_o = 32'h10; mw_d = 32'hDEADBEEF;
    #3;
    chk("lw_we", rf_we, 1);
    chk("lw_wr", rf_wr, 5);
    chk("lw_wd", rf_wd, 32'hDEADBEEF);
    chk("lw_ret0", retired, 0);
    // jal
    tick();
    mw_ir = mk(5'd3, 5'd9); mw_o = 32'h42;
    #3;
    chk("jal_wr", rf_wr, 31);
    chk("jal_wd", rf_wd, 32'h42);
    chk("lw_ret1", retired, 1);
    // setx 0x123
    tick();
    mw_ir = {5'b10101, 27'h123};
    #3;
    chk("setx_wr", rf_wr, 30);
    chk("setx_wd", rf_wd, 32'h123);
    // addi rd=0
    tick();
    mw_ir = mk(5'd5, 5'd0);
    #3;
    chk("addi0_we", rf_we, 0);
    tick();
    mw_ir = 0;
    #3;
    chk("ret_after4", retired, 4);

    // multdiv result with idle pipeline
    tick();
    md_set(1, 7, 32'h99, 0, 0);
    #3;
    chk("md_ready_idle", mdi.md_ready, 1);
    chk("md_same_cycle_we", rf_we, 0);
    tick();
    md_set(0, 0, 0, 0, 0);
    #3;
    chk("md_wr", rf_wr, 7);
    chk("md_wd", rf_wd, 32'h99);

    // starvation: 4 losses then forced stall
    tick();
    mw_ir = mk(5'd5, 5'd3); mw_o = 32'h11;
    md_set(1, 7, 32'h77, 0, 0);
    #3;
    chk("st_accept", mdi.md_ready, 1);
    chk("st_wr0", rf_wr, 3);
    tick();
    md_set(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      #3;
      chk("st_lose_stall", wb_stall, 0);
      chk("st_lose_wr", rf_wr, 3);
    end
    tick();
    #3;
    chk("st_stall", wb_stall, 1);
    chk("st_wr7", rf_wr, 7);
    chk("st_wd77", rf_wd, 32'h77);
    tick();
    #3;
    chk("st_held_stall", wb_stall, 0);
    chk("st_held_wr", rf_wr, 3);
    tick();
    mw_ir = 0;
    #3;
    chk("st_retired", retired, 10);

    // full buffer backpressure, then div exception
    tick();
    mw_ir = mk(5'd5, 5'd3);
    md_set(1, 9, 32'hAB, 0, 0);
    #3;
    chk("bp_accept", mdi.md_ready, 1);
    tick();
    md_set(1, 12, 32'hFFFF, 1, 1);
    #3;
    chk("bp_ready0", mdi.md_ready, 0);
    chk("bp_wr3", rf_wr, 3);
    tick();
    #3;
    chk("bp_ready0b", mdi.md_ready, 0);
    tick();
    mw_ir = 0;
    #3;
    chk("bp_drain_ready", mdi.md_ready, 1);
    chk("bp_drain_wr", rf_wr, 9);
    chk("bp_drain_wd", rf_wd, 32'hAB);
    tick();
    md_set(0, 0, 0, 0, 0);
    #3;
    chk("exc_wr", rf_wr, 30);
    chk("exc_wd", rf_wd, 5);

    // reset discards a waiting result
    tick();
    mw_ir = mk(5'd5, 5'd3);
    md_set(1, 4, 32'h55, 0, 0);
    tick();
    md_set(0, 0, 0, 0, 0);
    tick();
    reset = 1;
    #3;
    chk("rs_we", rf_we, 0);
    chk("rs_ready", mdi.md_ready, 0);
    chk("rs_stall", wb_stall, 0);
    tick();
    reset = 0; mw_ir = 0;
    #3;
    chk("rs_after_we", rf_we, 0);
    chk("rs_after_ret", retired, 0);
    chk("rs_after_ready", mdi.md_ready, 1);
    tick();
    #3;
    chk("rs_after_we2", rf_we, 0);

    // randomized traffic, latch holds on stall
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold_p = wb_stall;
      took = mdi.md_valid & mdi.md_ready;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 299) == 0);
      if (!hold_p) begin
        ir = {$urandom_range(0, 31), 27'($urandom)};
        if ($urandom_range(0, 3) == 0) ir[26:22] = 0;
        case ($urandom_range(0, 7))
          0: ir = 0;
          1: ir[31:27] = 5'd0;
          2, 7: ir[31:27] = 5'd5;
          3: ir[31:27] = 5'd8;
          4: ir[31:27] = 5'd3;
          5: ir[31:27] = 5'd21;
          default: ;
        endcase
        mw_ir = ir;
        mw_o = $urandom;
        mw_d = $urandom;
      end
      if (!mdi.md_valid || took) begin
        md_set($urandom_range(0, 9) < 4,
               ($urandom_range(0, 4) == 0) ? 5'd0
                 : 5'($urandom_range(1, 31)),
               $urandom,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 1) == 1);
      end
    end
    tick();
    reset = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
